// File: rtl/amba_pkg.sv
// amba_pkg: AHB/APB encodings and the bridge state enumeration.
package amba_pkg;
  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;
  localparam logic HRESP_OKAY = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_SETUP,
    S_ACCESS,
    S_DONE,
    S_ERR1,
    S_ERR2
  } br_state_e;
endpackage

// File: rtl/ahb_apb_bridge_if.sv
// ahb_apb_bridge_if: AHB-lite slave side and APB master side of the bridge.
interface ahb_apb_bridge_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready, prdata, pready, pslverr,
    output hreadyout, hresp, hrdata, psel, penable, pwrite, paddr, pwdata
  );
  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready, prdata, pready, pslverr,
    input  hreadyout, hresp, hrdata, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_timeout_ctr.sv
// apb_timeout_ctr: counts ACCESS wait cycles; expired pulses on the TIMEOUT-th one.
module apb_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic pclk,
  input  logic preset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [W-1:0] cnt;
  assign expired = (TIMEOUT != 0) && enable && (32'(cnt) + 32'd1 == 32'(TIMEOUT));
  always_ff @(posedge pclk or negedge preset)
    if (!preset) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/ahb_apb_bridge.sv
// ahb_apb_bridge: single-word AHB-lite transfers to APB SETUP/ACCESS, registered outputs.
module ahb_apb_bridge
  import amba_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input logic             pclk,
  input logic             preset,
  ahb_apb_bridge_if.slave bus
);
  br_state_e state, ns;
  logic acc, bad, expired;
  assign acc = bus.hsel && bus.hready && bus.htrans[1] && bus.hreadyout &&
               (state == S_IDLE || state == S_DONE);
  assign bad = bus.hsize != HSIZE_WORD || bus.haddr[1:0] != 2'b00;
  apb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_to (
    .pclk   (pclk),
    .preset (preset),
    .clear  (state == S_SETUP),
    .enable (state == S_ACCESS && !bus.pready),
    .expired(expired)
  );
  always_comb begin
    ns = S_IDLE;
    case (state)
      S_IDLE, S_DONE: ns = acc ? (bad ? S_ERR1 : bus.hwrite ? S_WDATA : S_SETUP) : S_IDLE;
      S_WDATA:        ns = S_SETUP;
      S_SETUP:        ns = S_ACCESS;
      S_ACCESS:       ns = bus.pready ? (bus.pslverr ? S_ERR1 : S_DONE) : expired ? S_ERR1 : S_ACCESS;
      S_ERR1:         ns = S_ERR2;
      default:        ns = S_IDLE;
    endcase
  end
  // outputs are decoded from the next state so they line up with it in the same cycle
  always_ff @(posedge pclk or negedge preset)
    if (!preset) begin
      state         <= S_IDLE;
      bus.hreadyout <= 1'b1;
      bus.hresp     <= HRESP_OKAY;
      bus.hrdata    <= '0;
      bus.psel      <= 1'b0;
      bus.penable   <= 1'b0;
      bus.pwrite    <= 1'b0;
      bus.paddr     <= '0;
      bus.pwdata    <= '0;
    end else begin
      state         <= ns;
      bus.hreadyout <= ns inside {S_IDLE, S_DONE, S_ERR2};
      bus.hresp     <= ns inside {S_ERR1, S_ERR2} ? HRESP_ERROR : HRESP_OKAY;
      bus.psel      <= ns inside {S_SETUP, S_ACCESS};
      bus.penable   <= ns == S_ACCESS;
      if (acc) begin
        bus.paddr  <= bus.haddr;
        bus.pwrite <= bus.hwrite;
      end
      if (state == S_WDATA) bus.pwdata <= bus.hwdata;
      if (state == S_ACCESS && bus.pready && !bus.pslverr && !bus.pwrite) bus.hrdata <= bus.prdata;
    end
endmodule

// File: tb/tb_ahb_apb_bridge.sv
// tb_ahb_apb_bridge: randomized transfers checked every cycle against a transaction-level timing model.
module tb_ahb_apb_bridge;
  import amba_pkg::*;
  localparam int TO = 16;
  logic pclk = 1'b0;
  logic preset = 1'b0;
  always #5 pclk = ~pclk;
  ahb_apb_bridge_if bus ();
  ahb_apb_bridge #(.TIMEOUT(TO)) dut (.pclk(pclk), .preset(preset), .bus(bus));
  int n_vec = 0;
  int n_err = 0;
  int run = 0;
  int last_run = 0;
  logic chk_en = 1'b0;
  logic e_hro, e_hresp, e_psel, e_pen;
  logic [31:0] e_hrdata;
  logic [31:0] m_hrdata = '0;
  logic [31:0] m_paddr = '0;
  logic [31:0] m_pwdata = '0;
  logic m_pwrite = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask
  always @(negedge pclk) begin
    if (chk_en) begin
      chk("hreadyout", 32'(bus.hreadyout), 32'(e_hro));
      chk("hresp", 32'(bus.hresp), 32'(e_hresp));
      chk("psel", 32'(bus.psel), 32'(e_psel));
      chk("penable", 32'(bus.penable), 32'(e_pen));
      chk("hrdata", bus.hrdata, e_hrdata);
      if (e_psel) begin
        chk("paddr", bus.paddr, m_paddr);
        chk("pwrite", 32'(bus.pwrite), 32'(m_pwrite));
        if (m_pwrite) chk("pwdata", bus.pwdata, m_pwdata);
      end
    end
    if (bus.penable === 1'b1) run++;
    else begin
      if (run > 0) last_run = run;
      run = 0;
    end
  end
  task automatic nxt();
    @(posedge pclk);
    #1;
  endtask
  task automatic expect_out(input logic hro, input logic hresp, input logic psel, input logic pen);
    e_hro = hro;
    e_hresp = hresp;
    e_psel = psel;
    e_pen = pen;
    e_hrdata = m_hrdata;
    chk_en = 1'b1;
  endtask
  task automatic bus_idle();
    bus.hsel = 1'($urandom);
    bus.htrans = 2'($urandom_range(0, 1));
    bus.haddr = $urandom;
    bus.hwrite = 1'($urandom);
    bus.hsize = 3'($urandom);
    bus.hready = 1'b1;
    bus.hwdata = $urandom;
    bus.pready = 1'($urandom);
    bus.pslverr = 1'($urandom);
    bus.prdata = $urandom;
  endtask
  task automatic idle_cyc();
    nxt();
    expect_out(1'b1, 1'b0, 1'b0, 1'b0);
    bus_idle();
  endtask
  task automatic err_tail();
    nxt();
    expect_out(1'b0, 1'b1, 1'b0, 1'b0);
    bus_idle();
    nxt();
    expect_out(1'b1, 1'b1, 1'b0, 1'b0);
    bus_idle();
    bus.hsel = 1'b1;
    bus.htrans = HT_NONSEQ;
    bus.hsize = HSIZE_WORD;
    bus.haddr = $urandom & 32'hFFFF_FFFC;
  endtask
  // cycle 0 runs in the current IDLE/DONE cycle; returns in the last cycle before DONE/IDLE
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] sz,
                      input logic [31:0] wd, input int waits, input logic err, input logic [31:0] rd);
    int n_acc;
    logic [1:0] lo;
    nxt();
    expect_out(1'b1, 1'b0, 1'b0, 1'b0);
    bus_idle();
    bus.hsel = 1'b1;
    bus.htrans = HT_NONSEQ;
    bus.haddr = addr;
    bus.hwrite = wr;
    bus.hsize = sz;
    lo = addr[1:0];
    if (sz != HSIZE_WORD || lo != 2'b00) begin
      err_tail();
      return;
    end
    m_paddr = addr;
    m_pwrite = wr;
    if (wr) begin
      nxt();
      expect_out(1'b0, 1'b0, 1'b0, 1'b0);
      bus_idle();
      bus.hwdata = wd;
      m_pwdata = wd;
    end
    nxt();
    expect_out(1'b0, 1'b0, 1'b1, 1'b0);
    bus_idle();
    n_acc = waits >= TO ? TO : waits + 1;
    for (int i = 0; i < n_acc; i++) begin
      nxt();
      expect_out(1'b0, 1'b0, 1'b1, 1'b1);
      bus_idle();
      bus.pready = i == waits;
      bus.pslverr = i == waits ? err : 1'($urandom);
      bus.prdata = i == waits ? rd : $urandom;
    end
    if (waits >= TO || err) err_tail();
    else if (!wr) m_hrdata = rd;
  endtask
  initial begin
    logic wr, er;
    logic [2:0] sz;
    logic [31:0] addr;
    int waits, k;
    bus_idle();
    bus.hsel = 1'b0;
    #12;
    chk("rst_hreadyout", 32'(bus.hreadyout), 32'd1);
    chk("rst_hresp", 32'(bus.hresp), 32'd0);
    chk("rst_psel", 32'(bus.psel), 32'd0);
    chk("rst_penable", 32'(bus.penable), 32'd0);
    chk("rst_pwrite", 32'(bus.pwrite), 32'd0);
    chk("rst_hrdata", bus.hrdata, 32'd0);
    chk("rst_paddr", bus.paddr, 32'd0);
    chk("rst_pwdata", bus.pwdata, 32'd0);
    preset = 1'b1;
    xfer(32'h0000_1004, 1'b0, HSIZE_WORD, 32'd0, 0, 1'b0, 32'hDEAD_BEEF);
    idle_cyc();
    chk("read_hrdata", bus.hrdata, 32'hDEAD_BEEF);
    chk("read_done_hreadyout", 32'(bus.hreadyout), 32'd1);
    xfer(32'h10, 1'b1, HSIZE_WORD, 32'hA5A5_0001, 3, 1'b0, 32'h0);
    idle_cyc();
    idle_cyc();
    chk("write_access_cycles", 32'(last_run), 32'd4);
    chk("write_paddr", bus.paddr, 32'h10);
    chk("write_pwdata", bus.pwdata, 32'hA5A5_0001);
    xfer(32'h20, 1'b0, HSIZE_WORD, 32'd0, 1, 1'b1, 32'h1111_2222);
    idle_cyc();
    chk("slverr_hrdata", bus.hrdata, 32'hDEAD_BEEF);
    xfer(32'h24, 1'b0, 3'b000, 32'd0, 0, 1'b0, 32'd0);
    xfer(32'h2, 1'b1, HSIZE_WORD, 32'd0, 0, 1'b0, 32'd0);
    nxt();
    expect_out(1'b1, 1'b0, 1'b0, 1'b0);
    bus_idle();
    bus.hsel = 1'b1;
    bus.htrans = HT_BUSY;
    xfer(32'h30, 1'b0, HSIZE_WORD, 32'd0, 40, 1'b0, 32'd0);
    idle_cyc();
    chk("timeout_access_cycles", 32'(last_run), 32'd16);
    xfer(32'h40, 1'b0, HSIZE_WORD, 32'd0, 0, 1'b0, 32'h0BAD_F00D);
    xfer(32'h44, 1'b0, HSIZE_WORD, 32'd0, 15, 1'b0, 32'hCAFE_0044);
    idle_cyc();
    chk("b2b_hrdata", bus.hrdata, 32'hCAFE_0044);
    nxt();
    expect_out(1'b1, 1'b0, 1'b0, 1'b0);
    bus_idle();
    bus.hsel = 1'b1;
    bus.htrans = HT_NONSEQ;
    bus.haddr = 32'h50;
    bus.hwrite = 1'b0;
    bus.hsize = HSIZE_WORD;
    m_paddr = 32'h50;
    m_pwrite = 1'b0;
    nxt();
    expect_out(1'b0, 1'b0, 1'b1, 1'b0);
    bus_idle();
    nxt();
    expect_out(1'b0, 1'b0, 1'b1, 1'b1);
    bus_idle();
    bus.pready = 1'b0;
    #2;
    chk_en = 1'b0;
    preset = 1'b0;
    #1;
    chk("midrst_psel", 32'(bus.psel), 32'd0);
    chk("midrst_penable", 32'(bus.penable), 32'd0);
    chk("midrst_hreadyout", 32'(bus.hreadyout), 32'd1);
    m_hrdata = '0;
    @(negedge pclk);
    #2;
    preset = 1'b1;
    xfer(32'h60, 1'b0, HSIZE_WORD, 32'd0, 2, 1'b0, 32'h1234_5678);
    idle_cyc();
    chk("post_reset_hrdata", bus.hrdata, 32'h1234_5678);
    for (int t = 0; t < 300; t++) begin
      k = $urandom_range(0, 2);
      repeat (k) idle_cyc();
      wr = 1'($urandom);
      waits = $urandom_range(0, 9) == 0 ? $urandom_range(TO - 1, TO + 3) : $urandom_range(0, 4);
      sz = $urandom_range(0, 9) == 0 ? 3'($urandom) : HSIZE_WORD;
      addr = $urandom;
      if ($urandom_range(0, 9) != 0) addr = addr & 32'hFFFF_FFFC;
      er = $urandom_range(0, 7) == 0;
      xfer(addr, wr, sz, $urandom, waits, er, $urandom);
    end
    idle_cyc();
    idle_cyc();
    @(posedge pclk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
